fired_tag_fifo: RTL and testbench
=================================

Name: fired_tag_fifo

Overview:
- Producer-side queue of fired-neuron tags, and the responder for the synaptic processing unit's dequeue interface (fifo_empty / req_deq / src_tag).
- The neuron update unit pushes the tag of each neuron that fires in the current timestep.
- The synaptic processing unit pops one tag per synaptic update job.
- The block also tracks timestep drain: it suppresses duplicate fires within a step and signals step completion once every fired tag has been consumed.

Parameters:
- numneurons, 2, number of neurons; also the queue depth (one entry per neuron per step).
- tagbits, 1, neuron tag width; must satisfy 2^tagbits >= numneurons.

Ports:
- clk  in  1  system clock, rising edge.
- asyn_reset_n  in  1  asynchronous, active-low reset.
- fire_valid  in  1  neuron update unit presents a fired tag this cycle.
- fire_tag  in  tagbits  tag of the firing neuron.
- step_end  in  1  one-cycle pulse: neuron update pass for this timestep finished; no more fires expected.
- req_deq  in  1  SPU pops head entry.
- fifo_empty  out  1  queue holds no entries.
- fifo_full  out  1  queue holds numneurons entries.
- src_tag_out  out  tagbits  head entry, first-word fall-through; valid when fifo_empty=0.
- step_done  out  1  one-cycle pulse: step ended and queue fully drained.
- busy  out  1  FSM not in IDLE.
- dup_drop  out  1  one-cycle pulse: fire_valid was dropped as a duplicate.
- err_overflow  out  1  sticky: push attempted while full.
- err_underflow  out  1  sticky: req_deq asserted while empty.
- err_late  out  1  sticky: fire_valid asserted during DRAIN.

Behaviour:
- Reset (asyn_reset_n=0, asynchronous): rd_ptr, wr_ptr and count =0; pending bitmap cleared; FSM=IDLE.
  - Output values in reset: fifo_empty=1, fifo_full=0, src_tag_out=0, step_done=0, busy=0, dup_drop=0, all err_* =0.
  - Reset mid-step discards all queued tags.
- Storage: numneurons x tagbits register array.
  - Pointers wrap from numneurons-1 to 0 explicitly; non-power-of-two depth is legal.
  - count has width clog2(numneurons+1).
- Output derivation:
  - fifo_empty = (count==0); fifo_full = (count==numneurons); both registered-state derived, no combinational path from inputs.
  - src_tag_out = mem[rd_ptr] when not empty, else 0.
- Push: on a clk edge with fire_valid=1, pending[fire_tag]=0 and (not full, or req_deq=1 with count>0), the tag is written at wr_ptr, wr_ptr advances and pending[fire_tag] is set.
- Duplicate: fire_valid=1 with pending[fire_tag]=1 means no write; dup_drop pulses next cycle.
- Overflow: fire_valid=1, not a duplicate, full and no simultaneous pop means no write; err_overflow sets.
- Pop: on a clk edge with req_deq=1 and count>0, rd_ptr advances.
  - The entry is visible to the SPU on src_tag_out during the cycle req_deq is high; the next entry appears the following cycle.
  - req_deq while empty: ignored, err_underflow sets. No bypass: a simultaneous push into an empty queue is stored and the pop is ignored.
- Simultaneous push and pop with count>0: both occur, count unchanged (valid even when full).
- Duplicate check: pending bits are not cleared by a pop. Each neuron fires at most once per timestep.
- FSM:
  - IDLE: accepts pushes and pops. On step_end go to DRAIN. If step_end arrives and count==0 with no push that cycle, go directly to DONE.
  - DRAIN: busy=1. Pushes are still accepted normally but set err_late. Pops continue. When count==0 and no push pending this cycle, go to DONE.
  - DONE: busy=1 for one cycle. step_done=1, all pending bits clear. Next state IDLE. A fire_valid in DONE is treated as the next step's first fire: it is stored with its pending bit set after the clear.
- step_end in DRAIN or DONE is ignored.
- Latency: push to fifo_empty deassert is 1 cycle; last pop to step_done is 1 cycle (DRAIN->DONE) + 1 (pulse).

Test Plan:
- Reset, then push tags 1,0 on consecutive cycles -> fifo_empty falls after first edge; src_tag_out=1. Pop -> src_tag_out=0 next cycle. Pop -> fifo_empty=1.
- numneurons=2: push 0,1 (full=1), push tag 1 again -> dup_drop pulse, count stays 2, err_overflow=0. Push an unseen tag (numneurons=3 build, full) -> err_overflow=1.
- Full queue, simultaneous push (new tag) and pop -> count unchanged, head advances, new tag lands at tail.
- Push 0,1, step_end, pop twice -> busy=1 through drain; step_done pulses exactly once 2 cycles after final pop. Push tag 0 afterwards is accepted (bitmap cleared).
- step_end on an empty queue -> step_done pulses within 2 cycles; req_deq while empty -> err_underflow=1, pointers unchanged.
- Assert asyn_reset_n low mid-DRAIN with 1 entry, asynchronously between edges -> fifo_empty=1, busy=0 immediately; all flags cleared.

Source files
------------

// File: rtl/fired_tag_fifo_if.sv
// Dequeue/fire handshake bundle between the neuron update unit, the SPU and
// the fired-tag queue; master drives requests, slave is the queue.
interface fired_tag_fifo_if #(
    parameter int tagbits = 1
);
    logic               fire_valid;
    logic [tagbits-1:0] fire_tag;
    logic               step_end;
    logic               req_deq;
    logic               fifo_empty;
    logic               fifo_full;
    logic [tagbits-1:0] src_tag_out;
    logic               step_done;
    logic               busy;
    logic               dup_drop;
    logic               err_overflow;
    logic               err_underflow;
    logic               err_late;

    modport master (
        output fire_valid, fire_tag, step_end, req_deq,
        input  fifo_empty, fifo_full, src_tag_out, step_done, busy,
               dup_drop, err_overflow, err_underflow, err_late
    );

    modport slave (
        input  fire_valid, fire_tag, step_end, req_deq,
        output fifo_empty, fifo_full, src_tag_out, step_done, busy,
               dup_drop, err_overflow, err_underflow, err_late
    );
endinterface

// File: rtl/fired_tag_fifo.sv
// Queue of fired-neuron tags for one timestep, with duplicate suppression and
// drain tracking that pulses step_done once every fired tag has been popped.
module fired_tag_fifo #(
    parameter int numneurons = 2,
    parameter int tagbits    = 1
) (
    input  logic           clk,
    input  logic           asyn_reset_n,
    fired_tag_fifo_if.slave bus
);
    localparam int ptr_w = (numneurons > 1) ? $clog2(numneurons) : 1;
    localparam int cnt_w = $clog2(numneurons + 1);
    localparam int tag_n = 1 << tagbits;
    localparam logic [cnt_w-1:0] depth    = cnt_w'(numneurons);
    localparam logic [ptr_w-1:0] last_ptr = ptr_w'(numneurons - 1);

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    state_t             state;
    logic [tagbits-1:0] mem [numneurons];
    logic [ptr_w-1:0]   rd_ptr;
    logic [ptr_w-1:0]   wr_ptr;
    logic [cnt_w-1:0]   count;
    logic [tag_n-1:0]   pending;
    logic               busy_q;
    logic               step_done_q;
    logic               dup_q;
    logic               ovf_q;
    logic               udf_q;
    logic               late_q;

    logic is_empty;
    logic is_full;
    logic pend_hit;
    logic pop_ok;
    logic push_ok;
    logic drained;

    assign is_empty = (count == '0);
    assign is_full  = (count == depth);
    // DONE clears the bitmap, so a fire landing there belongs to the next step.
    assign pend_hit = (state != DONE) && pending[bus.fire_tag];
    assign pop_ok   = bus.req_deq && !is_empty;
    assign push_ok  = bus.fire_valid && !pend_hit && (!is_full || pop_ok);
    assign drained  = is_empty && !push_ok;

    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            pending     <= '0;
            state       <= IDLE;
            busy_q      <= 1'b0;
            step_done_q <= 1'b0;
            dup_q       <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            late_q      <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= (wr_ptr == last_ptr) ? '0 : wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= (rd_ptr == last_ptr) ? '0 : rd_ptr + 1'b1;

            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            pending <= ((state == DONE) ? '0 : pending)
                     | (push_ok ? (tag_n'(1) << bus.fire_tag) : '0);

            dup_q  <= bus.fire_valid && pend_hit;
            ovf_q  <= ovf_q  | (bus.fire_valid && !pend_hit && is_full && !pop_ok);
            udf_q  <= udf_q  | (bus.req_deq && is_empty);
            late_q <= late_q | (bus.fire_valid && (state == DRAIN));

            step_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.step_end) begin
                        state       <= drained ? DONE : DRAIN;
                        step_done_q <= drained;
                        busy_q      <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        state       <= DONE;
                        step_done_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: storage has no reset; entries are only visible through count, which is reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= bus.fire_tag;
    end

    assign bus.fifo_empty    = is_empty;
    assign bus.fifo_full     = is_full;
    assign bus.src_tag_out   = is_empty ? '0 : mem[rd_ptr];
    assign bus.step_done     = step_done_q;
    assign bus.busy          = busy_q;
    assign bus.dup_drop      = dup_q;
    assign bus.err_overflow  = ovf_q;
    assign bus.err_underflow = udf_q;
    assign bus.err_late      = late_q;
endmodule

// File: tb/tb_fired_tag_fifo.sv
// Drives a depth-2 and a depth-3 queue with directed and random traffic and
// compares every output each cycle against a list-based step model.
module tb_fired_tag_fifo;
    localparam int P_IDLE  = 0;
    localparam int P_DRAIN = 1;
    localparam int P_DONE  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    fired_tag_fifo_if #(.tagbits(1)) bus0 ();
    fired_tag_fifo_if #(.tagbits(2)) bus1 ();

    fired_tag_fifo #(.numneurons(2), .tagbits(1)) dut0 (
        .clk(clk), .asyn_reset_n(rst_n), .bus(bus0.slave));
    fired_tag_fifo #(.numneurons(3), .tagbits(2)) dut1 (
        .clk(clk), .asyn_reset_n(rst_n), .bus(bus1.slave));

    // Model: queue contents kept head-first as a plain list.
    int       m_cnt   [2];
    int       m_q     [2][4];
    bit [3:0] m_pend  [2];
    int       m_phase [2];
    bit       m_dup [2], m_ofl [2], m_ufl [2], m_late [2];

    task automatic check(string tag, int obs, int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_pend[i] = '0; m_phase[i] = P_IDLE;
            m_dup[i] = 0; m_ofl[i] = 0; m_ufl[i] = 0; m_late[i] = 0;
            for (int k = 0; k < 4; k++) m_q[i][k] = 0;
        end
    endtask

    task automatic model_step(int i, bit fv, int tag, bit se, bit rd);
        int depth    = (i == 0) ? 2 : 3;
        int c0       = m_cnt[i];
        bit in_done  = (m_phase[i] == P_DONE);
        bit seen     = !in_done && m_pend[i][tag];
        bit can_pop  = rd && (c0 > 0);
        bit push     = fv && !seen && ((c0 < depth) || can_pop);
        bit finished = (c0 == 0) && !push;
        m_dup[i]  = fv && seen;
        m_ofl[i]  = m_ofl[i] | (fv && !seen && (c0 == depth) && !can_pop);
        m_ufl[i]  = m_ufl[i] | (rd && (c0 == 0));
        m_late[i] = m_late[i] | (fv && (m_phase[i] == P_DRAIN));
        case (m_phase[i])
            P_IDLE:  if (se) m_phase[i] = finished ? P_DONE : P_DRAIN;
            P_DRAIN: if (finished) m_phase[i] = P_DONE;
            default: m_phase[i] = P_IDLE;
        endcase
        if (in_done) m_pend[i] = '0;
        if (can_pop) begin
            for (int k = 0; k < 3; k++) m_q[i][k] = m_q[i][k+1];
            m_cnt[i]--;
        end
        if (push) begin
            m_q[i][m_cnt[i]] = tag;
            m_cnt[i]++;
            m_pend[i][tag] = 1'b1;
        end
    endtask

    task automatic check_outs(int i, logic e, logic f, int src, logic sd, logic b,
                              logic dd, logic eo, logic eu, logic el);
        string p = (i == 0) ? "n2" : "n3";
        int depth = (i == 0) ? 2 : 3;
        check({p, ".fifo_empty"},    e,   m_cnt[i] == 0);
        check({p, ".fifo_full"},     f,   m_cnt[i] == depth);
        check({p, ".src_tag_out"},   src, (m_cnt[i] == 0) ? 0 : m_q[i][0]);
        check({p, ".step_done"},     sd,  m_phase[i] == P_DONE);
        check({p, ".busy"},          b,   m_phase[i] != P_IDLE);
        check({p, ".dup_drop"},      dd,  m_dup[i]);
        check({p, ".err_overflow"},  eo,  m_ofl[i]);
        check({p, ".err_underflow"}, eu,  m_ufl[i]);
        check({p, ".err_late"},      el,  m_late[i]);
    endtask

    task automatic check_all();
        check_outs(0, bus0.fifo_empty, bus0.fifo_full, bus0.src_tag_out, bus0.step_done,
                   bus0.busy, bus0.dup_drop, bus0.err_overflow, bus0.err_underflow,
                   bus0.err_late);
        check_outs(1, bus1.fifo_empty, bus1.fifo_full, bus1.src_tag_out, bus1.step_done,
                   bus1.busy, bus1.dup_drop, bus1.err_overflow, bus1.err_underflow,
                   bus1.err_late);
    endtask

    task automatic clear_inputs();
        bus0.fire_valid = 0; bus0.fire_tag = '0; bus0.step_end = 0; bus0.req_deq = 0;
        bus1.fire_valid = 0; bus1.fire_tag = '0; bus1.step_end = 0; bus1.req_deq = 0;
    endtask

    task automatic set0(bit fv, int tag, bit se, bit rd);
        bus0.fire_valid = fv; bus0.fire_tag = 1'(tag); bus0.step_end = se; bus0.req_deq = rd;
    endtask

    task automatic set1(bit fv, int tag, bit se, bit rd);
        bus1.fire_valid = fv; bus1.fire_tag = 2'(tag); bus1.step_end = se; bus1.req_deq = rd;
    endtask

    // Inputs are set between edges; the model consumes them at the edge the DUT does.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            model_step(0, bus0.fire_valid, int'(bus0.fire_tag), bus0.step_end, bus0.req_deq);
            model_step(1, bus1.fire_valid, int'(bus1.fire_tag), bus1.step_end, bus1.req_deq);
        end
        @(negedge clk);
        check_all();
        clear_inputs();
    endtask

    // Reset lands between edges to exercise the asynchronous path.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        #3 check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Push 1,0 then pop twice; depth-3 copy fills and then overflows on tag 3.
        set0(1, 1, 0, 0); set1(1, 0, 0, 0); tick();
        set0(1, 0, 0, 0); set1(1, 1, 0, 0); tick();
        set0(0, 0, 0, 1); set1(1, 2, 0, 0); tick();
        set0(0, 0, 0, 1); set1(1, 3, 0, 0); tick();
        tick();

        // Duplicate drop on a full queue, then a full timestep drain.
        async_reset();
        set0(1, 0, 0, 0); tick();
        set0(1, 1, 0, 0); tick();
        set0(1, 1, 0, 0); tick();
        set0(0, 0, 1, 0); tick();
        set0(0, 0, 0, 1); tick();
        set0(0, 0, 0, 1); tick();
        repeat (3) tick();
        set0(1, 0, 0, 0); tick();
        set0(0, 0, 0, 1); tick();

        // Step end on an empty queue, underflow; full depth-3 push-and-pop.
        async_reset();
        set0(0, 0, 1, 0); set1(1, 0, 0, 0); tick();
        set0(0, 0, 0, 1); set1(1, 1, 0, 0); tick();
        set1(1, 2, 0, 0); tick();
        set1(1, 3, 0, 1); tick();
        set1(0, 0, 0, 1); tick();
        repeat (2) tick();

        // Reset in the middle of a drain with one entry left.
        async_reset();
        set0(1, 0, 0, 0); tick();
        set0(1, 1, 0, 0); tick();
        set0(0, 0, 1, 1); tick();
        tick();
        async_reset();

        // Random traffic with occasional resets so sticky flags are re-armed.
        for (int n = 0; n < 1500; n++) begin
            set0($urandom_range(0, 1) == 1, $urandom_range(0, 1),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 4);
            set1($urandom_range(0, 1) == 1, $urandom_range(0, 3),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 4);
            tick();
            if ($urandom_range(0, 149) == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
